// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and halt drain control
// for the five-stage 16-bit pipeline, plus a stall-cycle counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  idRs,
    input  logic        idRsValid,
    input  logic [2:0]  idRt,
    input  logic        idRtValid,
    input  logic [2:0]  exWriteReg,
    input  logic        exWriteRegValid,
    input  logic        exRegWrite,
    input  logic        exMemRead,
    input  logic        exBranchTaken,
    input  logic        exHalt,
    input  logic        exErr,
    input  logic        memStall,
    output logic        writePc,
    output logic        writeIfId,
    output logic        flushIfId,
    output logic        writeIdEx,
    output logic        controlZeroIdEx1,
    output logic        controlZeroIdEx2,
    output logic        halted,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LU   = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;
    logic   luHaz;
    logic   stallInc;

    // Load-use: the EX load targets a register the decode instruction reads.
    always_comb begin
        luHaz = exMemRead & exRegWrite & exWriteRegValid &
                ((idRsValid & (idRs == exWriteReg)) |
                 (idRtValid & (idRt == exWriteReg)));
    end

    // Enables, bubbles and next state, highest-priority condition first.
    always_comb begin
        writePc          = 1'b1;
        writeIfId        = 1'b1;
        writeIdEx        = 1'b1;
        flushIfId        = 1'b0;
        controlZeroIdEx1 = 1'b0;
        controlZeroIdEx2 = 1'b0;
        halted           = 1'b0;
        stallInc         = 1'b0;
        stateNext        = state;
        if (rst) begin
            writePc   = 1'b0;
            writeIfId = 1'b0;
            writeIdEx = 1'b0;
            stateNext = RUN;
        end else begin
            case (state)
                HALT: begin
                    writePc          = 1'b0;
                    writeIfId        = 1'b0;
                    controlZeroIdEx1 = 1'b1;
                    halted           = 1'b1;
                end
                RUN, LU: begin
                    if (memStall) begin
                        writePc   = 1'b0;
                        writeIfId = 1'b0;
                        writeIdEx = 1'b0;
                        stallInc  = 1'b1;
                    end else if (state == LU) begin
                        stateNext = RUN;
                    end else if (exHalt | exErr) begin
                        controlZeroIdEx2 = 1'b1;
                        flushIfId        = 1'b1;
                        writePc          = 1'b0;
                        stateNext        = HALT;
                    end else if (exBranchTaken) begin
                        controlZeroIdEx2 = 1'b1;
                        flushIfId        = 1'b1;
                    end else if (luHaz) begin
                        writePc          = 1'b0;
                        writeIfId        = 1'b0;
                        controlZeroIdEx1 = 1'b1;
                        stallInc         = 1'b1;
                        stateNext        = LU;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    // State register; reset forces RUN without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Stall-cycle counter that sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= 16'd0;
        end else if (stallInc && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl
// against a behavioural model of the stall/flush/halt rules.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  idRs;
    logic        idRsValid;
    logic [2:0]  idRt;
    logic        idRtValid;
    logic [2:0]  exWriteReg;
    logic        exWriteRegValid;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exBranchTaken;
    logic        exHalt;
    logic        exErr;
    logic        memStall;
    logic        writePc;
    logic        writeIfId;
    logic        flushIfId;
    logic        writeIdEx;
    logic        controlZeroIdEx1;
    logic        controlZeroIdEx2;
    logic        halted;
    logic [15:0] stallCount;

    int testCount = 0;
    int failCount = 0;

    // Model: is the front end frozen, was a bubble just inserted, stall total.
    bit mHalted = 0;
    bit mBubble = 0;
    int mCount  = 0;

    hazard_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .idRs             (idRs),
        .idRsValid        (idRsValid),
        .idRt             (idRt),
        .idRtValid        (idRtValid),
        .exWriteReg       (exWriteReg),
        .exWriteRegValid  (exWriteRegValid),
        .exRegWrite       (exRegWrite),
        .exMemRead        (exMemRead),
        .exBranchTaken    (exBranchTaken),
        .exHalt           (exHalt),
        .exErr            (exErr),
        .memStall         (memStall),
        .writePc          (writePc),
        .writeIfId        (writeIfId),
        .flushIfId        (flushIfId),
        .writeIdEx        (writeIdEx),
        .controlZeroIdEx1 (controlZeroIdEx1),
        .controlZeroIdEx2 (controlZeroIdEx2),
        .halted           (halted),
        .stallCount       (stallCount)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outVec();
        return {writePc, writeIfId, flushIfId, writeIdEx,
                controlZeroIdEx1, controlZeroIdEx2, halted};
    endfunction

    function automatic int satAdd(int a, int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    task automatic clearInputs();
        rst = 0; idRs = 0; idRsValid = 0; idRt = 0; idRtValid = 0;
        exWriteReg = 0; exWriteRegValid = 0; exRegWrite = 0;
        exMemRead = 0; exBranchTaken = 0; exHalt = 0; exErr = 0;
        memStall = 0;
    endtask

    task automatic checkVal(string tag, logic [15:0] got, logic [15:0] exp);
        testCount++;
        assert (got === exp) else begin
            failCount++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check the current cycle against the model at the falling edge,
    // advance the model, then cross the rising edge.
    task automatic step(string tag);
        logic [6:0] exp;
        bit readsLoad;
        bit nHalted, nBubble;
        int nCount;
        @(negedge clk);
        readsLoad = exMemRead && exRegWrite && exWriteRegValid &&
                    ((idRsValid && idRs == exWriteReg) ||
                     (idRtValid && idRt == exWriteReg));
        nHalted = mHalted;
        nBubble = 0;
        nCount  = mCount;
        // bits: writePc writeIfId flushIfId writeIdEx cz1 cz2 halted
        if (rst) begin
            exp = 7'b0000000;
            nHalted = 0;
            nCount  = 0;
            mCount  = 0;
        end else if (mHalted) begin
            exp = 7'b0001101;
        end else if (memStall) begin
            exp = 7'b0000000;
            nBubble = mBubble;
            nCount = satAdd(mCount, 1);
        end else if (mBubble) begin
            exp = 7'b1101000;
        end else if (exHalt || exErr) begin
            exp = 7'b0111010;
            nHalted = 1;
        end else if (exBranchTaken) begin
            exp = 7'b1111010;
        end else if (readsLoad) begin
            exp = 7'b0001100;
            nBubble = 1;
            nCount = satAdd(mCount, 1);
        end else begin
            exp = 7'b1101000;
        end
        checkVal({tag, ".outs"}, {9'd0, outVec()}, {9'd0, exp});
        checkVal({tag, ".count"}, stallCount, mCount[15:0]);
        mHalted = nHalted;
        mBubble = nBubble;
        mCount  = nCount;
        @(posedge clk);
        #1;
    endtask

    task automatic setLoadUse(logic [2:0] r);
        exMemRead = 1; exRegWrite = 1; exWriteRegValid = 1;
        exWriteReg = r; idRs = r; idRsValid = 1;
    endtask

    task automatic doReset();
        rst = 1;
        step("reset");
        rst = 0;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        #2;
        checkVal("async_reset_outs", {9'd0, outVec()}, 16'd0);
        doReset();
        step("idle");
        checkVal("idle_default", {9'd0, outVec()}, 16'b1101000);

        // Load-use on Rs: one bubble, then defaults while in LU.
        setLoadUse(3'd3);
        step("lu_stall");
        step("lu_bubble");
        clearInputs();
        step("lu_after");
        checkVal("lu_count_one", stallCount, 16'd1);

        // Rs invalid, Rt differs: no hazard.
        doReset();
        setLoadUse(3'd3);
        idRsValid = 0; idRt = 3'd5; idRtValid = 1;
        step("no_haz");
        step("no_haz2");
        checkVal("no_haz_count", stallCount, 16'd0);

        // Branch wins over load-use; next cycle stalls normally.
        setLoadUse(3'd2);
        exBranchTaken = 1;
        step("br_lu");
        exBranchTaken = 0;
        step("br_next_lu");
        clearInputs();
        step("br_after");

        // memStall held 4 cycles while in LU.
        setLoadUse(3'd6);
        idRs = 3'd0; idRsValid = 0; idRt = 3'd6; idRtValid = 1;
        step("lu2_stall");
        clearInputs();
        memStall = 1;
        for (int i = 0; i < 4; i++) step("lu2_mem");
        memStall = 0;
        step("lu2_exit");
        step("lu2_run");
        checkVal("lu2_count", stallCount, 16'd6);

        // Halt: flush, then frozen even under memStall.
        exHalt = 1;
        setLoadUse(3'd1);
        step("halt_flush");
        clearInputs();
        memStall = 1;
        for (int i = 0; i < 3; i++) step("halt_hold");
        checkVal("halt_halted", {15'd0, halted}, 16'd1);
        rst = 1;
        #1;
        checkVal("halt_async_rst", {9'd0, outVec()}, 16'd0);
        checkVal("halt_async_cnt", stallCount, 16'd0);
        mHalted = 0; mBubble = 0; mCount = 0;
        step("halt_rst");
        clearInputs();

        // Error takes the same halt path.
        exErr = 1;
        step("err_flush");
        exErr = 0;
        step("err_halted");
        doReset();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            idRs = 3'($urandom_range(0, 3));
            idRt = 3'($urandom_range(0, 3));
            exWriteReg = 3'($urandom_range(0, 3));
            idRsValid = 1'($urandom);
            idRtValid = 1'($urandom);
            exWriteRegValid = ($urandom_range(0, 3) != 0);
            exRegWrite = ($urandom_range(0, 3) != 0);
            exMemRead = 1'($urandom);
            memStall = ($urandom_range(0, 3) == 0);
            exBranchTaken = !mBubble && ($urandom_range(0, 7) == 0);
            exHalt = !mBubble && ($urandom_range(0, 63) == 0);
            exErr = !mBubble && ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 39) == 0);
            step("rand");
        end
        clearInputs();

        // Saturation after 65540 memStall cycles.
        doReset();
        memStall = 1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        mCount = satAdd(mCount, 65540);
        checkVal("sat_count", stallCount, 16'hFFFF);
        step("sat_hold");
        checkVal("sat_still", stallCount, 16'hFFFF);
        clearInputs();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage 16-bit processor. It sits upstream of the ID/EX pipeline register and generates that register's `writeIdEx`, `controlZeroIdEx1` (load-use bubble) and `controlZeroIdEx2` (control-flow flush) inputs. It also generates the PC and IF/ID write and flush enables. A small state machine sequences load-use stalls and the halt/error drain, and a saturating counter records stall cycles for performance debug.

## Interface
- No parameters.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `idRs` input 3: source register Rs of the instruction in IF/ID (decode).
- `idRsValid` input 1: instruction reads Rs.
- `idRt` input 3: source register Rt of the instruction in IF/ID.
- `idRtValid` input 1: instruction reads Rt.
- `exWriteReg` input 3: destination register of the instruction in EX (ID/EX output).
- `exWriteRegValid` input 1: destination is valid.
- `exRegWrite` input 1: EX instruction writes the register file.
- `exMemRead` input 1: EX instruction is a load.
- `exBranchTaken` input 1: EX resolved a taken branch or jump this cycle.
- `exHalt` input 1: HaltOut of ID/EX.
- `exErr` input 1: errOut of ID/EX.
- `memStall` input 1: data memory busy; the whole pipeline must freeze.
- `writePc` output 1: PC register write enable.
- `writeIfId` output 1: IF/ID register write enable.
- `flushIfId` output 1: load a NOP into IF/ID on this edge.
- `writeIdEx` output 1: ID/EX register write enable.
- `controlZeroIdEx1` output 1: bubble ID/EX (load-use or halt drain).
- `controlZeroIdEx2` output 1: flush ID/EX (taken branch, jump, halt or error).
- `halted` output 1: pipeline front end is frozen after a halt or error.
- `stallCount` output 16: saturating count of stall cycles.

## Operation
- Load-use hazard: `luHaz` = `exMemRead` & `exRegWrite` & `exWriteRegValid` & ((`idRsValid` & `idRs`==`exWriteReg`) | (`idRtValid` & `idRt`==`exWriteReg`)). All other RAW hazards are covered by forwarding and are not this block's concern.
- States:
  - RUN: normal flow.
  - LU: one bubble has been inserted behind a load.
  - HALT: terminal.
- Default outputs: `writePc`=`writeIfId`=`writeIdEx`=1; `flushIfId`, both controlZero outputs and `halted` are 0.
- Priority within a cycle, highest first: reset, HALT state, `memStall`, halt/error, branch, load-use.
- HALT state:
  - Outputs: `writePc`=0, `writeIfId`=0, `writeIdEx`=1, `controlZeroIdEx1`=1, `halted`=1.
  - `memStall` is ignored so that older instructions keep draining.
  - HALT is left only by reset.
- `memStall`=1 (state RUN or LU):
  - All three write enables are 0; all zero/flush outputs are 0.
  - State is held and `stallCount` increments.
- RUN with `exHalt`|`exErr`:
  - Outputs: `controlZeroIdEx2`=1, `flushIfId`=1, `writePc`=0.
  - Next state HALT. This condition overrides `exBranchTaken` and `luHaz`.
- RUN with `exBranchTaken`:
  - Outputs: `controlZeroIdEx2`=1, `flushIfId`=1; write enables stay 1.
  - `luHaz` is ignored because the younger instruction is being squashed. Next state RUN.
- RUN with `luHaz`:
  - Outputs: `writePc`=0, `writeIfId`=0, `writeIdEx`=1, `controlZeroIdEx1`=1.
  - Next state LU; `stallCount` increments.
- LU:
  - Outputs are the defaults; hazard detection is suppressed.
  - Next state is RUN unless `memStall` holds the state.
- `stallCount`:
  - Increments by 1 on a `memStall` cycle or a load-use bubble cycle.
  - Saturates at 16'hFFFF and never wraps.

## Timing
- State and `stallCount` are registered on the rising `clk`. All enable, flush and zero outputs are combinational from state and inputs in the same cycle.
- A load-use stall lasts exactly 1 cycle, after which a MEM-to-EX forward supplies the load result.
- A branch flush costs 2 squashed instructions (IF/ID and ID/EX) and acts on the same edge that EX resolves the branch.
- The halt drain enters HALT one edge after `exHalt` is seen in EX. From the next edge on, ID/EX loads only bubbles.
- Behaviour while `rst`=1:
  - All outputs are 0, including the write enables, `halted` and `stallCount`.
  - State is RUN.
  - Asserting `rst` mid-stall or in HALT returns to RUN immediately, with no edge required.

## Test plan
- Load `exMemRead`=1, `exRegWrite`=1, `exWriteReg`=3, with `idRs`=3 and `idRsValid`=1 -> for 1 cycle `writePc`=0, `writeIfId`=0 and `controlZeroIdEx1`=1; the next cycle is the default (LU); `stallCount`=1.
- Same as above but `idRsValid`=0 and `idRt`=5 -> no stall; `stallCount` stays 0.
- `exBranchTaken`=1 together with `luHaz`=1 -> `controlZeroIdEx2`=1, `flushIfId`=1, `controlZeroIdEx1`=0, `writePc`=1, and the next state is RUN.
- `memStall` held 4 cycles during LU -> all write enables 0 for 4 cycles, the state stays LU, `stallCount` rises by 4, then LU exits to RUN.
- `exHalt`=1 (or `exErr`=1) -> flush in that cycle, then `halted`=1 permanently with `controlZeroIdEx1`=1 even while `memStall`=1; a `rst` pulse clears everything to 0.
- Force 65540 `memStall` cycles -> `stallCount` holds 16'hFFFF.
